// File: rtl/shift_ram_reader.sv
// shift_ram_reader: read sequencer for the shift RAM, streaming words through a 2-entry buffer
// Ports: clk_i, rst_ni (async active-low); start_i/count_i launch a burst; ram_clear_i zeroes the
// mirrored pointer and aborts a running burst; ram_en_o/ram_we_o/ram_rdata_i drive the RAM read port;
// m_data_o/m_valid_o/m_ready_i form the output stream; busy_o, done_o, overrun_o, rd_pos_o report status.
// Option: define SHIFT_RAM_READER_CHECKSUM_EN to add checksum_o, the per-burst sum of accepted words.
module shift_ram_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 156800
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic              ram_clear_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [ADDR_W-1:0] rd_pos_o
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] rem_q, rem_d, pos_q, pos_d, room;
  logic ovr_q, ovr_d, infl_q, infl_d, hd_q, hd_d;
  logic [1:0] occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic pop, en, abort, go;
  assign room  = DEPTH_C - pos_q;
  assign pop   = (occ_q != 2'd0) && m_ready_i;
  assign abort = ram_clear_i && (state_q == RUN || state_q == DRAIN);
  assign go    = state_q == IDLE && start_i && !ram_clear_i;
  // Credit rule: a strobe is allowed only if the word it returns is guaranteed a buffer slot.
  assign en = state_q == RUN && rem_q != '0 && pos_q != DEPTH_C && !ram_clear_i &&
              ({1'b0, occ_q} + 3'(infl_q) < 3'd2 + 3'(pop));
  assign ram_en_o  = en;
  assign ram_we_o  = 1'b0;
  assign m_valid_o = occ_q != 2'd0;
  assign m_data_o  = m_valid_o ? mem_q[hd_q] : '0;
  assign busy_o    = state_q == RUN || state_q == DRAIN;
  assign done_o    = state_q == FIN;
  assign overrun_o = ovr_q;
  assign rd_pos_o  = pos_q;
  always_comb begin
    state_d = state_q;
    rem_d   = en ? rem_q - ONE : rem_q;
    pos_d   = en ? pos_q + ONE : pos_q;
    ovr_d   = ovr_q;
    infl_d  = en;
    hd_d    = hd_q ^ pop;
    occ_d   = occ_q + 2'(infl_q) - 2'(pop);
    mem_d   = mem_q;
    // The credit rule keeps occupancy at most 1 whenever a word lands, so the tail is head or head^1.
    if (infl_q) mem_d[hd_q ^ occ_q[0]] = ram_rdata_i;
    case (state_q)
      IDLE: if (go) begin
        rem_d   = count_i > room ? room : count_i;
        ovr_d   = ovr_q | (count_i > room);
        state_d = (count_i == '0 || room == '0) ? FIN : RUN;
      end
      RUN:     state_d = (rem_q == '0 && !infl_q) ? DRAIN : RUN;
      DRAIN:   state_d = occ_q == 2'd0 ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
    if (ram_clear_i) begin
      pos_d = '0;
      ovr_d = 1'b0;
    end
    if (abort) begin
      state_d = FIN;
      rem_d   = '0;
      infl_d  = 1'b0;
      occ_d   = 2'd0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      pos_q   <= '0;
      ovr_q   <= 1'b0;
      infl_q  <= 1'b0;
      hd_q    <= 1'b0;
      occ_q   <= 2'd0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      ovr_q   <= ovr_d;
      infl_q  <= infl_d;
      hd_q    <= hd_d;
      occ_q   <= occ_d;
      mem_q   <= mem_d;
    end
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;
  assign cks_d = go ? '0 : pop ? cks_q + m_data_o : cks_q;
  assign checksum_o = cks_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cks_q <= '0;
    else cks_q <= cks_d;
`endif
endmodule

// File: tb/tb_shift_ram_reader.sv
// tb_shift_ram_reader: directed bench for shift_ram_reader with a small DEPTH so the end of RAM is reachable
module tb_shift_ram_reader;
  localparam int DW = 16, AW = 18, DEPTH = 40;
  logic clk = 0, rst_n = 0, start = 0, ram_clear = 0, m_ready = 0;
  logic [AW-1:0] count = '0;
  logic ram_en, ram_we, m_valid, busy, done, overrun;
  logic [DW-1:0] ram_rdata, m_data;
  logic [AW-1:0] rd_pos;
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif
  int checks = 0, errors = 0, en_cnt = 0, done_cnt = 0;
  logic last_valid = 0, last_ready = 0;
  logic [DW-1:0] last_data = '0;
  logic [31:0] ptr;
  logic [DW-1:0] got [$];

  always #5 clk = ~clk;

  shift_ram_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .count_i(count), .ram_clear_i(ram_clear),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata), .m_data_o(m_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .busy_o(busy), .done_o(done),
    .overrun_o(overrun), .rd_pos_o(rd_pos)
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  // RAM preloaded with mem[i] = i, auto-incrementing read pointer, one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= 0;
      ram_rdata <= '0;
    end else if (ram_clear) ptr <= 0;
    else if (ram_en) begin
      ram_rdata <= ptr[DW-1:0];
      ptr <= ptr + 1;
    end

  task automatic cyc();
    #1;
    if (m_valid && m_ready) got.push_back(m_data);
    if (ram_en) en_cnt++;
    if (done) done_cnt++;
    last_valid = m_valid;
    last_ready = m_ready;
    last_data = m_data;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n);
    got.delete();
    en_cnt = 0;
    done_cnt = 0;
    start = 1;
    count = AW'(n);
    cyc();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({ram_en, ram_we, m_valid, busy, done, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: en/we/valid/busy/done/ovr=%b want 000000", {ram_en, ram_we, m_valid, busy, done, overrun});
    end
    checks++;
    if (rd_pos !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_values: rd_pos=%0d m_data=%0d want 0 0", rd_pos, m_data);
    end
    rst_n = 1;
    m_ready = 1;
    cyc();
  endtask

  task automatic test_basic();
    launch(8);
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: busy=%b m_valid=%b want 1 0", busy, m_valid);
    end
    cyc();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1: m_valid=%b want 0", m_valid);
    end
    cyc();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd0) begin
      errors++;
      $display("FAIL basic_first_word: m_valid=%b m_data=%0d want 1 0", m_valid, m_data);
    end
    wait_done(40);
    cyc();
    cyc();
    checks++;
    if (done_cnt != 1 || en_cnt != 8) begin
      errors++;
      $display("FAIL basic_counts: done=%0d en=%0d want 1 8", done_cnt, en_cnt);
    end
    checks++;
    if (rd_pos !== AW'(8) || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: rd_pos=%0d busy=%b want 8 0", rd_pos, busy);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL basic_len: got %0d words want 8", got.size());
    end else foreach (got[i]) begin
      checks++;
      if (got[i] !== DW'(i)) begin
        errors++;
        $display("FAIL basic_word%0d: got %0d want %0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    launch(6);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      m_ready = (i % 3 == 0);
      cyc();
      if (last_valid && !last_ready) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== last_data) begin
          errors++;
          $display("FAIL bp_hold: m_valid=%b m_data=%0d want 1 %0d", m_valid, m_data, last_data);
        end
      end
    end
    m_ready = 1;
    checks++;
    if (done_cnt != 1 || en_cnt != 6 || rd_pos !== AW'(14)) begin
      errors++;
      $display("FAIL bp_counts: done=%0d en=%0d rd_pos=%0d want 1 6 14", done_cnt, en_cnt, rd_pos);
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_len: got %0d words want 6", got.size());
    end else foreach (got[i]) begin
      checks++;
      if (got[i] !== DW'(8 + i)) begin
        errors++;
        $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], 8 + i);
      end
    end
  endtask

  task automatic test_overrun();
    launch(24);
    wait_done(80);
    checks++;
    if (rd_pos !== AW'(38) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_setup: rd_pos=%0d overrun=%b want 38 0", rd_pos, overrun);
    end
    cyc();
    launch(5);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: overrun=%b want 1", overrun);
    end
    wait_done(30);
    checks++;
    if (en_cnt != 2 || done_cnt != 1 || rd_pos !== AW'(40)) begin
      errors++;
      $display("FAIL ovr_clip: en=%0d done=%0d rd_pos=%0d want 2 1 40", en_cnt, done_cnt, rd_pos);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 16'd38 || got[1] !== 16'd39) begin
      errors++;
      $display("FAIL ovr_words: got %0d words first=%0d want 2 words 38,39", got.size(), got.size() ? got[0] : 16'd0);
    end
    cyc();
    launch(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL ovr_full: done=%b busy=%b ram_en=%b want 1 0 0", done, busy, ram_en);
    end
    cyc();
    checks++;
    if (en_cnt != 0 || overrun !== 1'b1 || rd_pos !== AW'(40)) begin
      errors++;
      $display("FAIL ovr_full_end: en=%0d overrun=%b rd_pos=%0d want 0 1 40", en_cnt, overrun, rd_pos);
    end
  endtask

  task automatic test_zero_ignore();
    ram_clear = 1;
    cyc();
    ram_clear = 0;
    checks++;
    if (rd_pos !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: rd_pos=%0d overrun=%b want 0 0", rd_pos, overrun);
    end
    launch(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy);
    end
    cyc();
    checks++;
    if (en_cnt != 0) begin
      errors++;
      $display("FAIL zero_en: en=%0d want 0", en_cnt);
    end
    launch(4);
    cyc();
    start = 1;
    count = AW'(20);
    cyc();
    start = 0;
    wait_done(40);
    checks++;
    if (en_cnt != 4 || rd_pos !== AW'(4) || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_start: en=%0d rd_pos=%0d done=%0d want 4 4 1", en_cnt, rd_pos, done_cnt);
    end
    checks++;
    if (got.size() != 4 || got[3] !== 16'd3) begin
      errors++;
      $display("FAIL ignore_words: got %0d words want 4 ending 3", got.size());
    end
    cyc();
  endtask

  task automatic test_abort();
    launch(50);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL abort_ovr_set: overrun=%b want 1", overrun);
    end
    cyc();
    cyc();
    ram_clear = 1;
    cyc();
    ram_clear = 0;
    checks++;
    if (m_valid !== 1'b0 || ram_en !== 1'b0 || rd_pos !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: m_valid=%b ram_en=%b rd_pos=%0d overrun=%b want 0 0 0 0", m_valid, ram_en, rd_pos, overrun);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || en_cnt != 2) begin
      errors++;
      $display("FAIL abort_done: done=%b busy=%b en=%0d want 1 0 2", done, busy, en_cnt);
    end
    cyc();
    launch(3);
    wait_done(30);
    checks++;
    if (got.size() != 3 || got[0] !== 16'd0 || got[2] !== 16'd2) begin
      errors++;
      $display("FAIL abort_resume: got %0d words want 0,1,2", got.size());
    end
    cyc();
  endtask

  task automatic test_async_reset();
    launch(5);
    cyc();
    cyc();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ram_en, m_valid, busy, done, overrun} !== 5'b0 || rd_pos !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL async_reset: en/valid/busy/done/ovr=%b rd_pos=%0d m_data=%0d want 0", {ram_en, m_valid, busy, done, overrun}, rd_pos, m_data);
    end
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("FAIL async_checksum: checksum=%0d want 0", checksum);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc();
  endtask

`ifdef SHIFT_RAM_READER_CHECKSUM_EN
  task automatic test_checksum();
    launch(4);
    wait_done(30);
    cyc();
    checks++;
    if (checksum !== 16'd6) begin
      errors++;
      $display("FAIL cks_sum: checksum=%0d want 6", checksum);
    end
    launch(2);
    checks++;
    if (checksum !== 16'd0) begin
      errors++;
      $display("FAIL cks_clear: checksum=%0d want 0", checksum);
    end
    wait_done(30);
    checks++;
    if (checksum !== 16'd9) begin
      errors++;
      $display("FAIL cks_sum2: checksum=%0d want 9", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_zero_ignore();
    test_abort();
    test_async_reset();
`ifdef SHIFT_RAM_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
